dma_ctrl: RTL and testbench

DMA_CTRL -- requirements
Module: dma_ctrl

---
 rtl/dma_ctrl.sv | 159 +++++++++++++++
 tb/tb_dma_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_ctrl.sv
// Single-channel memory-to-memory DMA engine: copies LEN words from SRC to DST
// one read/write beat pair at a time, with slave registers for setup and status.
module dma_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_data_o,
  input  logic [31:0] m_data_i,
  output logic        m_req_o,
  output logic        m_we_o,
  input  logic        m_gnt_i,
  output logic        int_sig_o
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t      state;
  logic [31:0] src;
  logic [31:0] dst;
  logic [31:0] len;
  logic [31:0] buffer;
  logic        int_en;
  logic        done;
  logic        aborted;

  logic        busy;
  logic        ctrl_wr;
  logic        status_wr;
  logic        start;
  logic        abort;
  logic        unused_addr;

  assign busy      = (state != IDLE);
  assign ctrl_wr   = we_i && (addr_i[7:0] == 8'h00);
  assign status_wr = we_i && (addr_i[7:0] == 8'h10);
  // START+ABORT together in IDLE starts the transfer: abort only counts while busy
  assign start     = ctrl_wr && data_i[0] && !busy;
  assign abort     = ctrl_wr && data_i[2] && busy;
  assign int_sig_o = int_en & (done | aborted);
  assign unused_addr = ^addr_i[31:8];

  always_comb begin
    data_o = 32'h0;
    case (addr_i[7:0])
      8'h00:   data_o = {29'b0, 1'b0, int_en, 1'b0};
      8'h04:   data_o = src;
      8'h08:   data_o = dst;
      8'h0C:   data_o = len;
      8'h10:   data_o = {29'b0, aborted, done, busy};
      default: data_o = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      src      <= 32'h0;
      dst      <= 32'h0;
      len      <= 32'h0;
      buffer   <= 32'h0;
      int_en   <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      m_req_o  <= 1'b0;
      m_we_o   <= 1'b0;
      m_addr_o <= 32'h0;
      m_data_o <= 32'h0;
    end else begin
      if (we_i && !busy) begin
        case (addr_i[7:0])
          8'h00:   int_en <= data_i[1];
          8'h04:   src    <= data_i;
          8'h08:   dst    <= data_i;
          8'h0C:   len    <= data_i;
          default: ;
        endcase
      end

      // clears come first so a hardware set in the same cycle wins
      if (status_wr && data_i[1]) done    <= 1'b0;
      if (status_wr && data_i[2]) aborted <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            if (len != 32'h0) begin
              state    <= RD;
              m_req_o  <= 1'b1;
              m_we_o   <= 1'b0;
              m_addr_o <= src;
              m_data_o <= 32'h0;
            end else begin
              state <= FIN;
            end
          end
        end

        RD: begin
          if (m_gnt_i) buffer <= m_data_i;
          if (abort) begin
            state    <= IDLE;
            aborted  <= 1'b1;
            m_req_o  <= 1'b0;
            m_we_o   <= 1'b0;
            m_addr_o <= 32'h0;
            m_data_o <= 32'h0;
          end else if (m_gnt_i) begin
            state    <= WR;
            m_we_o   <= 1'b1;
            m_addr_o <= dst;
            m_data_o <= m_data_i;
          end
        end

        WR: begin
          if (m_gnt_i) begin
            src <= src + 32'd4;
            dst <= dst + 32'd4;
            len <= len - 32'd1;
          end
          if (abort) begin
            state    <= IDLE;
            aborted  <= 1'b1;
            m_req_o  <= 1'b0;
            m_we_o   <= 1'b0;
            m_addr_o <= 32'h0;
            m_data_o <= 32'h0;
          end else if (m_gnt_i) begin
            if (len == 32'd1) begin
              state    <= FIN;
              m_req_o  <= 1'b0;
              m_we_o   <= 1'b0;
              m_addr_o <= 32'h0;
              m_data_o <= 32'h0;
            end else begin
              state    <= RD;
              m_we_o   <= 1'b0;
              m_addr_o <= src + 32'd4;
              m_data_o <= 32'h0;
            end
          end
        end

        FIN: begin
          state <= IDLE;
          if (abort) aborted <= 1'b1;
          else       done    <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl: a memory stub answers reads with addr^0xA5A50000,
// a monitor logs every completed beat, and each step checks against hand values.
module tb_dma_ctrl;

  logic        clk;
  logic        rst_n;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_data_o;
  logic [31:0] m_data_i;
  logic        m_req_o;
  logic        m_we_o;
  logic        m_gnt_i;
  logic        int_sig_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] log_addr [64];
  logic [31:0] log_data [64];
  logic        log_we   [64];
  int          beat_n = 0;

  dma_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .m_addr_o  (m_addr_o),
    .m_data_o  (m_data_o),
    .m_data_i  (m_data_i),
    .m_req_o   (m_req_o),
    .m_we_o    (m_we_o),
    .m_gnt_i   (m_gnt_i),
    .int_sig_o (int_sig_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_data_i = m_addr_o ^ 32'hA5A5_0000;

  always @(posedge clk) begin
    if (rst_n && m_req_o && m_gnt_i && beat_n < 64) begin
      log_addr[beat_n] <= m_addr_o;
      log_data[beat_n] <= m_we_o ? m_data_o : m_data_i;
      log_we[beat_n]   <= m_we_o;
      beat_n           <= beat_n + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=no_finish expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_now(input string tag, input logic [7:0] a, input logic [31:0] exp);
    addr_i = {24'h0, a};
    #1;
    chk(tag, data_o, exp);
  endtask

  task automatic chk_reg(input string tag, input logic [7:0] a, input logic [31:0] exp);
    @(negedge clk);
    chk_now(tag, a, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    we_i   = 1'b1;
    addr_i = {24'h0, a};
    data_i = d;
    $display("wr addr=0x%02h data=0x%08h", a, d);
    @(negedge clk);
    we_i   = 1'b0;
    addr_i = 32'h0;
    data_i = 32'h0;
  endtask

  task automatic count_busy(output int n);
    addr_i = 32'h10;
    #1;
    n = 0;
    while (data_o[0] === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    int base;
    rst_n   = 1'b0;
    we_i    = 1'b0;
    addr_i  = 32'h0;
    data_i  = 32'h0;
    m_gnt_i = 1'b1;

    // reset state
    #3;
    chk("rst_req",  {31'b0, m_req_o}, 32'h0);
    chk("rst_addr", m_addr_o, 32'h0);
    chk("rst_int",  {31'b0, int_sig_o}, 32'h0);
    chk_now("rst_status", 8'h10, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 3-word copy with permanent grant
    wr(8'h04, 32'h0000_1000);
    wr(8'h08, 32'h0000_2000);
    wr(8'h0C, 32'd3);
    base = beat_n;
    wr(8'h00, 32'h3);
    count_busy(n);
    chk("a_busy_cycles", n, 32'd7);
    chk("a_beats", beat_n - base, 32'd6);
    chk("a_rd0_addr", log_addr[base+0], 32'h0000_1000);
    chk("a_wr0_addr", log_addr[base+1], 32'h0000_2000);
    chk("a_wr0_data", log_data[base+1], 32'hA5A5_1000);
    chk("a_wr0_we",   {31'b0, log_we[base+1]}, 32'h1);
    chk("a_rd2_addr", log_addr[base+4], 32'h0000_1008);
    chk("a_wr2_addr", log_addr[base+5], 32'h0000_2008);
    chk("a_wr2_data", log_data[base+5], 32'hA5A5_1008);
    chk("a_int", {31'b0, int_sig_o}, 32'h1);
    chk("a_idle_req", {31'b0, m_req_o}, 32'h0);
    chk_reg("a_src", 8'h04, 32'h0000_100C);
    chk_reg("a_dst", 8'h08, 32'h0000_200C);
    chk_reg("a_len", 8'h0C, 32'h0);
    chk_reg("a_status", 8'h10, 32'h2);
    chk_reg("a_ctrl", 8'h00, 32'h2);

    // LEN=0: straight to FIN with no bus traffic
    wr(8'h10, 32'h2);
    chk_reg("b_clr_status", 8'h10, 32'h0);
    wr(8'h0C, 32'h0);
    base = beat_n;
    wr(8'h00, 32'h3);
    chk_now("b_fin_busy", 8'h10, 32'h1);
    chk("b_no_req", {31'b0, m_req_o}, 32'h0);
    chk_reg("b_done", 8'h10, 32'h2);
    chk("b_no_beats", beat_n - base, 32'd0);
    chk("b_int_on", {31'b0, int_sig_o}, 32'h1);
    wr(8'h10, 32'h2);
    chk_reg("b_w1c", 8'h10, 32'h0);
    chk("b_int_off", {31'b0, int_sig_o}, 32'h0);

    // grant withheld five cycles in RD, int_en cleared
    m_gnt_i = 1'b0;
    wr(8'h04, 32'h0000_3000);
    wr(8'h08, 32'h0000_4000);
    wr(8'h0C, 32'd1);
    wr(8'h00, 32'h1);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("c_hold_req",  {31'b0, m_req_o}, 32'h1);
      chk("c_hold_we",   {31'b0, m_we_o}, 32'h0);
      chk("c_hold_addr", m_addr_o, 32'h0000_3000);
      @(negedge clk);
    end
    m_gnt_i = 1'b1;
    @(negedge clk);
    #1;
    chk("c_wr_we",   {31'b0, m_we_o}, 32'h1);
    chk("c_wr_addr", m_addr_o, 32'h0000_4000);
    chk("c_wr_data", m_data_o, 32'hA5A5_3000);
    @(negedge clk);
    #1;
    chk("c_fin_req", {31'b0, m_req_o}, 32'h0);
    chk_reg("c_status", 8'h10, 32'h2);
    chk("c_int_masked", {31'b0, int_sig_o}, 32'h0);
    chk_reg("c_src", 8'h04, 32'h0000_3004);

    // SRC wraps past 2^32
    wr(8'h10, 32'h6);
    wr(8'h04, 32'hFFFF_FFFC);
    wr(8'h08, 32'h0000_5000);
    wr(8'h0C, 32'd2);
    base = beat_n;
    wr(8'h00, 32'h1);
    count_busy(n);
    chk("d_busy_cycles", n, 32'd5);
    chk("d_rd0_addr", log_addr[base+0], 32'hFFFF_FFFC);
    chk("d_rd1_addr", log_addr[base+2], 32'h0000_0000);
    chk("d_wr1_data", log_data[base+3], 32'hA5A5_0000);
    chk_reg("d_src", 8'h04, 32'h0000_0004);

    // ABORT during WR of word 2 of 4 with no grant
    wr(8'h10, 32'h6);
    wr(8'h04, 32'h0000_0100);
    wr(8'h08, 32'h0000_0200);
    wr(8'h0C, 32'd4);
    wr(8'h00, 32'h3);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("e_wr2_we",   {31'b0, m_we_o}, 32'h1);
    chk("e_wr2_addr", m_addr_o, 32'h0000_0204);
    m_gnt_i = 1'b0;
    we_i    = 1'b1;
    addr_i  = 32'h0;
    data_i  = 32'h4;
    $display("wr addr=0x00 data=0x00000004 (abort)");
    @(negedge clk);
    we_i   = 1'b0;
    data_i = 32'h0;
    #1;
    chk("e_req_off", {31'b0, m_req_o}, 32'h0);
    chk_now("e_status", 8'h10, 32'h4);
    chk_reg("e_len", 8'h0C, 32'd3);
    chk_reg("e_src", 8'h04, 32'h0000_0104);
    chk("e_int", {31'b0, int_sig_o}, 32'h1);
    wr(8'h10, 32'h4);
    chk_reg("e_clr", 8'h10, 32'h0);
    chk("e_int_off", {31'b0, int_sig_o}, 32'h0);

    // START+ABORT in IDLE starts; busy-time writes ignored; reset mid-RD
    wr(8'h04, 32'h0000_0600);
    wr(8'h0C, 32'd1);
    wr(8'h00, 32'h7);
    #1;
    chk("f_started", {31'b0, m_req_o}, 32'h1);
    wr(8'h04, 32'h0000_DEAD);
    chk_now("f_src_locked", 8'h04, 32'h0000_0600);
    base = beat_n;
    #1;
    rst_n = 1'b0;
    #1;
    chk("f_rst_req",  {31'b0, m_req_o}, 32'h0);
    chk("f_rst_we",   {31'b0, m_we_o}, 32'h0);
    chk("f_rst_addr", m_addr_o, 32'h0);
    chk_now("f_rst_src", 8'h04, 32'h0);
    @(negedge clk);
    m_gnt_i = 1'b1;
    rst_n   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("f_post_rst_req", {31'b0, m_req_o}, 32'h0);
    end
    chk("f_post_rst_beats", beat_n - base, 32'd0);
    chk_reg("f_post_rst_status", 8'h10, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
